// File: rtl/bffma_pkg.sv
// Shared widths and constants for the BF16 fused multiply-add datapath.
package bffma_pkg;

    localparam int DEF_EXP_WIDTH  = 8;
    localparam int DEF_SIG_WIDTH  = 7;
    localparam int DEF_CSIG_WIDTH = 23;
    localparam int DEF_BIAS       = 127;

    localparam int PROD_WIDTH = 2 * (DEF_SIG_WIDTH + 1);
    localparam int SEXP_WIDTH = DEF_EXP_WIDTH + 2;

    localparam logic [DEF_EXP_WIDTH-1:0] EXP_ALL_ONES = {DEF_EXP_WIDTH{1'b1}};

endpackage

// File: rtl/bffma_pipe_ctrl.sv
// Two-slot valid/ready controller for the product stage: one valid bit per
// pipeline stage, each stage loads when empty or draining the same cycle.
module bffma_pipe_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in_valid,
    input  logic i_out_ready,
    output logic o_in_ready,
    output logic o_s1_load,
    output logic o_s2_load,
    output logic o_out_valid
);

    logic r_s1_valid;
    logic r_s2_valid;

    assign o_s2_load   = r_s1_valid & (~r_s2_valid | i_out_ready);
    assign o_in_ready  = rst_n & (~r_s1_valid | o_s2_load);
    assign o_s1_load   = i_in_valid & o_in_ready;
    assign o_out_valid = r_s2_valid;

    // Stage occupancy: fill on load, empty when contents move on without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (o_s1_load | o_s2_load) begin
                r_s1_valid <= o_s1_load;
            end
            if (o_s2_load | i_out_ready) begin
                r_s2_valid <= o_s2_load;
            end
        end
    end

endmodule

// File: rtl/bffma_mul_stage.sv
// Two-stage A*B product stage of the BF16 FMA: decode/clean in S1, exact
// multiply and exponent arithmetic in S2. Optional macro: BFFMA_SPECIAL_EN.
module bffma_mul_stage
    import bffma_pkg::*;
#(
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int SIG_WIDTH  = DEF_SIG_WIDTH,
    parameter int CSIG_WIDTH = DEF_CSIG_WIDTH,
    parameter int BIAS       = DEF_BIAS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            aIsSubnormal,
    input  logic                            bIsSubnormal,
    input  logic                            cIsSubnormal,
    input  logic                            aSign,
    input  logic                            bSign,
    input  logic                            cSign,
    input  logic [EXP_WIDTH-1:0]            aExp,
    input  logic [EXP_WIDTH-1:0]            bExp,
    input  logic [EXP_WIDTH-1:0]            cExp,
    input  logic [SIG_WIDTH:0]              aSig,
    input  logic [SIG_WIDTH:0]              bSig,
    input  logic [CSIG_WIDTH:0]             cSig,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            prodSign,
    output logic signed [EXP_WIDTH+1:0]     prodExp,
    output logic [2*(SIG_WIDTH+1)-1:0]      prodSig,
    output logic signed [EXP_WIDTH+1:0]     expDiff,
    output logic                            cSignOut,
    output logic [EXP_WIDTH-1:0]            cExpOut,
    output logic [CSIG_WIDTH:0]             cSigOut,
    output logic                            prodZero,
    output logic                            cZero,
    output logic                            prodNaN,
    output logic                            prodInf,
    output logic                            cNaN,
    output logic                            cInf
);

    localparam int SW = SIG_WIDTH + 1;
    localparam int PW = 2 * SW;
    localparam int XW = EXP_WIDTH + 2;
    localparam int CW = CSIG_WIDTH + 1;

    logic w_s1_load;
    logic w_s2_load;

    bffma_pipe_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_s1_load   (w_s1_load),
        .o_s2_load   (w_s2_load),
        .o_out_valid (out_valid)
    );

    // The unpacker marks true zero with a hidden bit, so zero is decoded here.
    logic                 w_a_zero, w_b_zero, w_c_zero;
    logic [EXP_WIDTH-1:0] w_a_eff, w_b_eff, w_c_eff;
    logic [SW-1:0]        w_a_sig, w_b_sig;

    assign w_a_zero = (aExp == {EXP_WIDTH{1'b0}}) & ~aIsSubnormal;
    assign w_b_zero = (bExp == {EXP_WIDTH{1'b0}}) & ~bIsSubnormal;
    assign w_c_zero = (cExp == {EXP_WIDTH{1'b0}}) & ~cIsSubnormal;
    assign w_a_eff  = aIsSubnormal ? EXP_WIDTH'(1'b1) : aExp;
    assign w_b_eff  = bIsSubnormal ? EXP_WIDTH'(1'b1) : bExp;
    assign w_c_eff  = cIsSubnormal ? EXP_WIDTH'(1'b1) : cExp;
    assign w_a_sig  = w_a_zero ? {SW{1'b0}} : aSig;
    assign w_b_sig  = w_b_zero ? {SW{1'b0}} : bSig;

    logic                 r1_a_sign, r1_b_sign, r1_c_sign;
    logic [EXP_WIDTH-1:0] r1_a_eff, r1_b_eff, r1_c_eff, r1_c_exp;
    logic [SW-1:0]        r1_a_sig, r1_b_sig;
    logic [CW-1:0]        r1_c_sig;
    logic                 r1_prod_zero, r1_c_zero;

    // S1 register: decoded operand fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_a_sign    <= 1'b0;
            r1_b_sign    <= 1'b0;
            r1_c_sign    <= 1'b0;
            r1_a_eff     <= {EXP_WIDTH{1'b0}};
            r1_b_eff     <= {EXP_WIDTH{1'b0}};
            r1_c_eff     <= {EXP_WIDTH{1'b0}};
            r1_c_exp     <= {EXP_WIDTH{1'b0}};
            r1_a_sig     <= {SW{1'b0}};
            r1_b_sig     <= {SW{1'b0}};
            r1_c_sig     <= {CW{1'b0}};
            r1_prod_zero <= 1'b0;
            r1_c_zero    <= 1'b0;
        end else if (w_s1_load) begin
            r1_a_sign    <= aSign;
            r1_b_sign    <= bSign;
            r1_c_sign    <= cSign;
            r1_a_eff     <= w_a_eff;
            r1_b_eff     <= w_b_eff;
            r1_c_eff     <= w_c_eff;
            r1_c_exp     <= cExp;
            r1_a_sig     <= w_a_sig;
            r1_b_sig     <= w_b_sig;
            r1_c_sig     <= cSig;
            r1_prod_zero <= w_a_zero | w_b_zero;
            r1_c_zero    <= w_c_zero;
        end
    end

    // Zero-extended exponent sums cannot wrap in XW signed bits.
    logic [XW-1:0] w_prod_exp;
    logic [XW-1:0] w_exp_diff;
    logic [PW-1:0] w_prod_sig;

    assign w_prod_exp = {2'b00, r1_a_eff} + {2'b00, r1_b_eff} - XW'(BIAS);
    assign w_exp_diff = w_prod_exp - {2'b00, r1_c_eff};
    assign w_prod_sig = PW'(r1_a_sig) * PW'(r1_b_sig);

    logic                 r2_prod_sign, r2_c_sign;
    logic [XW-1:0]        r2_prod_exp, r2_exp_diff;
    logic [PW-1:0]        r2_prod_sig;
    logic [EXP_WIDTH-1:0] r2_c_exp;
    logic [CW-1:0]        r2_c_sig;
    logic                 r2_prod_zero, r2_c_zero;

    // S2 register: product, exponents and carried C fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_prod_sign <= 1'b0;
            r2_c_sign    <= 1'b0;
            r2_prod_exp  <= {XW{1'b0}};
            r2_exp_diff  <= {XW{1'b0}};
            r2_prod_sig  <= {PW{1'b0}};
            r2_c_exp     <= {EXP_WIDTH{1'b0}};
            r2_c_sig     <= {CW{1'b0}};
            r2_prod_zero <= 1'b0;
            r2_c_zero    <= 1'b0;
        end else if (w_s2_load) begin
            r2_prod_sign <= r1_a_sign ^ r1_b_sign;
            r2_c_sign    <= r1_c_sign;
            r2_prod_exp  <= w_prod_exp;
            r2_exp_diff  <= w_exp_diff;
            r2_prod_sig  <= w_prod_sig;
            r2_c_exp     <= r1_c_exp;
            r2_c_sig     <= r1_c_sig;
            r2_prod_zero <= r1_prod_zero;
            r2_c_zero    <= r1_c_zero;
        end
    end

    assign prodSign = r2_prod_sign;
    assign prodExp  = r2_prod_exp;
    assign prodSig  = r2_prod_sig;
    assign expDiff  = r2_exp_diff;
    assign cSignOut = r2_c_sign;
    assign cExpOut  = r2_c_exp;
    assign cSigOut  = r2_c_sig;
    assign prodZero = r2_prod_zero;
    assign cZero    = r2_c_zero;

`ifdef BFFMA_SPECIAL_EN
    localparam logic [EXP_WIDTH-1:0] ONES = {EXP_WIDTH{1'b1}};

    logic w_a_frac_nz, w_b_frac_nz, w_c_frac_nz;
    logic w_a_nan, w_b_nan, w_c_nan, w_a_inf, w_b_inf, w_c_inf;
    logic w_prod_nan, w_prod_inf;

    assign w_a_frac_nz = |aSig[SIG_WIDTH-1:0];
    assign w_b_frac_nz = |bSig[SIG_WIDTH-1:0];
    assign w_c_frac_nz = |cSig[CSIG_WIDTH-1:0];
    assign w_a_nan     = (aExp == ONES) &  w_a_frac_nz;
    assign w_a_inf     = (aExp == ONES) & ~w_a_frac_nz;
    assign w_b_nan     = (bExp == ONES) &  w_b_frac_nz;
    assign w_b_inf     = (bExp == ONES) & ~w_b_frac_nz;
    assign w_c_nan     = (cExp == ONES) &  w_c_frac_nz;
    assign w_c_inf     = (cExp == ONES) & ~w_c_frac_nz;
    // Inf times zero is invalid and reported as NaN.
    assign w_prod_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_prod_inf  = (w_a_inf | w_b_inf) & ~w_prod_nan;

    logic [3:0] r1_spec, r2_spec;

    // Special-value flags travel alongside the data through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_spec <= 4'b0000;
            r2_spec <= 4'b0000;
        end else begin
            if (w_s1_load) begin
                r1_spec <= {w_prod_nan, w_prod_inf, w_c_nan, w_c_inf};
            end
            if (w_s2_load) begin
                r2_spec <= r1_spec;
            end
        end
    end

    assign prodNaN = r2_spec[3];
    assign prodInf = r2_spec[2];
    assign cNaN    = r2_spec[1];
    assign cInf    = r2_spec[0];
`else
    assign prodNaN = 1'b0;
    assign prodInf = 1'b0;
    assign cNaN    = 1'b0;
    assign cInf    = 1'b0;
`endif

endmodule
